// File: rtl/pwl_pkg.sv
// pwl_pkg: shared types and fixed-point constants for the piecewise-linear
// activation pipeline.
//   pwl_mode_e  - per-beat function select (SIGMOID / TANH)
//   pwl_ctrl_t  - control payload carried alongside data through the stages
//   X_SAT, X_MID, X_ONE, C_HI, C_MID, C_LO, ONE - breakpoints and offsets as
//   functions of the fractional width f.
package pwl_pkg;

    localparam int unsigned PWL_W_DEF = 20;
    localparam int unsigned PWL_F_DEF = 16;

    typedef enum logic {
        SIGMOID = 1'b0,
        TANH    = 1'b1
    } pwl_mode_e;

    // Control payload: input sign and function select travel with the data.
    typedef struct packed {
        logic      neg;
        pwl_mode_e mode;
    } pwl_ctrl_t;

    // 1.0
    function automatic int unsigned ONE(input int unsigned f);
        return 32'd1 << f;
    endfunction

    // 5.0: saturation breakpoint
    function automatic int unsigned X_SAT(input int unsigned f);
        return 32'd5 << f;
    endfunction

    // 2.375: upper-middle breakpoint
    function automatic int unsigned X_MID(input int unsigned f);
        return 32'd19 << (f - 32'd3);
    endfunction

    // 1.0: lower-middle breakpoint
    function automatic int unsigned X_ONE(input int unsigned f);
        return 32'd1 << f;
    endfunction

    // 0.84375: offset of the slope-1/32 segment
    function automatic int unsigned C_HI(input int unsigned f);
        return 32'd27 << (f - 32'd5);
    endfunction

    // 0.625: offset of the slope-1/8 segment
    function automatic int unsigned C_MID(input int unsigned f);
        return 32'd5 << (f - 32'd3);
    endfunction

    // 0.5: offset of the slope-1/4 segment
    function automatic int unsigned C_LO(input int unsigned f);
        return 32'd1 << (f - 32'd1);
    endfunction

endpackage

// File: rtl/pwl_segment.sv
// pwl_segment: combinational piecewise-linear core f(a) on an unsigned
// magnitude. Shifts are logical and truncating.
//   a_i   - unsigned magnitude, W+1 bits, Q.F
//   f_c_o - f(a), W+1 bits, Q.F, in [0.5, 1.0] (combinational)
module pwl_segment
    import pwl_pkg::*;
#(
    parameter int unsigned W = PWL_W_DEF,
    parameter int unsigned F = PWL_F_DEF
) (
    input  logic [W:0] a_i,
    output logic [W:0] f_c_o
);

    localparam int unsigned AW = W + 1;

    localparam logic [W:0] K_ONE   = AW'(ONE(F));
    localparam logic [W:0] K_X_SAT = AW'(X_SAT(F));
    localparam logic [W:0] K_X_MID = AW'(X_MID(F));
    localparam logic [W:0] K_X_ONE = AW'(X_ONE(F));
    localparam logic [W:0] K_C_HI  = AW'(C_HI(F));
    localparam logic [W:0] K_C_MID = AW'(C_MID(F));
    localparam logic [W:0] K_C_LO  = AW'(C_LO(F));

    // Segment select, highest breakpoint first.
    always_comb begin
        f_c_o = K_ONE;
        if (a_i >= K_X_SAT) begin
            f_c_o = K_ONE;
        end else if (a_i >= K_X_MID) begin
            f_c_o = (a_i >> 5) + K_C_HI;
        end else if (a_i >= K_X_ONE) begin
            f_c_o = (a_i >> 3) + K_C_MID;
        end else begin
            f_c_o = (a_i >> 2) + K_C_LO;
        end
    end

endmodule

// File: rtl/pwl_act_pipe.sv
// pwl_act_pipe: three-stage piecewise-linear sigmoid/tanh unit with
// valid/ready flow control on both sides.
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake (in_ready is combinational)
//   in_x, in_mode        - signed Q.F sample, 0 = sigmoid / 1 = tanh
//   out_valid / out_ready- output handshake
//   out_z                - signed Q.F result
// Build option: define PWL_TANH_EN to build the tanh path; otherwise in_mode
// is ignored and every beat is sigmoid.
module pwl_act_pipe
    import pwl_pkg::*;
#(
    parameter int unsigned W = PWL_W_DEF,
    parameter int unsigned F = PWL_F_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z
);

    localparam int unsigned AW = W + 1;

    localparam logic [W-1:0] MAG_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W:0]   MAG_MAX_A = AW'(MAG_MAX);
    localparam logic [W:0]   K_ONE     = AW'(ONE(F));

    logic         en;
    pwl_mode_e    mode_in;
    logic [W-1:0] abs_x;
    logic [W:0]   mag;
    logic [W:0]   seg_f;

    logic         v1_q, v1_d;
    pwl_ctrl_t    ctl1_q, ctl1_d;
    logic [W:0]   mag1_q, mag1_d;

    logic         v2_q, v2_d;
    pwl_ctrl_t    ctl2_q, ctl2_d;
    logic [W:0]   y2_q, y2_d;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_z_q, out_z_d;

    // Whole pipeline advances together; a held output stalls every stage.
    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;

`ifdef PWL_TANH_EN
    logic [W:0] mag2;
    logic [W:0] t3;

    assign mode_in = pwl_mode_e'(in_mode);

    // tanh(x) = 2*sigmoid(2x) - 1: double the magnitude, saturating.
    always_comb begin
        mag2 = {mag[W-1:0], 1'b0};
        if (mag2 > MAG_MAX_A) begin
            mag2 = MAG_MAX_A;
        end
    end

    assign t3 = (y2_q << 1) - K_ONE;
`else
    logic unused_cfg;

    assign mode_in    = SIGMOID;
    assign unused_cfg = in_mode ^ ctl2_q.mode;
`endif

    // S1: magnitude, sign and mode capture.
    always_comb begin
        abs_x  = in_x[W-1] ? (~in_x + W'(1)) : in_x;
        // Only the most negative input still has its top bit set after negation.
        mag    = abs_x[W-1] ? MAG_MAX_A : AW'(abs_x);
        v1_d   = v1_q;
        ctl1_d = ctl1_q;
        mag1_d = mag1_q;
        if (en) begin
            v1_d        = in_valid;
            ctl1_d.neg  = in_x[W-1];
            ctl1_d.mode = mode_in;
            mag1_d      = mag;
`ifdef PWL_TANH_EN
            if (mode_in == TANH) begin
                mag1_d = mag2;
            end
`endif
        end
    end

    // S2: segment evaluation.
    pwl_segment #(
        .W (W),
        .F (F)
    ) u_segment (
        .a_i   (mag1_q),
        .f_c_o (seg_f)
    );

    always_comb begin
        v2_d   = v2_q;
        ctl2_d = ctl2_q;
        y2_d   = y2_q;
        if (en) begin
            v2_d   = v1_q;
            ctl2_d = ctl1_q;
            y2_d   = seg_f;
        end
    end

    // S3: symmetry and mode post-processing; out_z only moves on a real beat.
    always_comb begin
        out_valid_d = out_valid_q;
        out_z_d     = out_z_q;
        if (en) begin
            out_valid_d = v2_q;
            if (v2_q) begin
                out_z_d = W'(ctl2_q.neg ? (K_ONE - y2_q) : y2_q);
`ifdef PWL_TANH_EN
                if (ctl2_q.mode == TANH) begin
                    out_z_d = W'(ctl2_q.neg ? (AW'(0) - t3) : t3);
                end
`endif
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            ctl1_q      <= '0;
            mag1_q      <= '0;
            v2_q        <= 1'b0;
            ctl2_q      <= '0;
            y2_q        <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            ctl1_q      <= ctl1_d;
            mag1_q      <= mag1_d;
            v2_q        <= v2_d;
            ctl2_q      <= ctl2_d;
            y2_q        <= y2_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
        end
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// tb_pwl_act_pipe: scoreboard bench for pwl_act_pipe (W=20, F=16).
// The driver pushes the expected result of every accepted beat; a negedge
// monitor pops and compares whenever an output is handed off, and also
// watches stall/bubble hold behaviour. Honours PWL_TANH_EN like the design.
module tb_pwl_act_pipe;

    localparam int unsigned W = 20;
    localparam int unsigned F = 16;
    localparam longint ONE_L = longint'(1) << F;
    localparam longint MAXM  = (longint'(1) << (W - 1)) - 1;

`ifdef PWL_TANH_EN
    localparam bit TANH_ON = 1'b1;
`else
    localparam bit TANH_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_z;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_q[$];
    longint held_z   = 0;
    bit     was_stall = 1'b0;
    longint e_pop;

    longint corners[14] = '{0, 65536, 65535, 155648, 155647, 327680, 327679,
                            163840, 77824, 524287, -524288, -1, 1, 81920};

    pwl_act_pipe #(
        .W (W),
        .F (F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the four-segment curve written as plain integer arithmetic.
    function automatic longint f_ref(input longint a);
        if (a >= 5 * ONE_L) return ONE_L;
        if (8 * a >= 19 * ONE_L) return a / 32 + (27 * ONE_L) / 32;
        if (a >= ONE_L) return a / 8 + (5 * ONE_L) / 8;
        return a / 4 + ONE_L / 2;
    endfunction

    function automatic longint ref_out(input longint x, input bit m);
        longint a;
        longint y;
        a = (x < 0) ? -x : x;
        if (a > MAXM) a = MAXM;
        if (m && TANH_ON) begin
            a = 2 * a;
            if (a > MAXM) a = MAXM;
            y = 2 * f_ref(a) - ONE_L;
            return (x < 0) ? -y : y;
        end
        y = f_ref(a);
        return (x < 0) ? ONE_L - y : y;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cycle(input bit v, input logic [W-1:0] x, input bit m, input bit rdy,
                         input bit use_exp, input longint e, output bit acc);
        in_valid  = v;
        in_x      = x;
        in_mode   = m;
        out_ready = rdy;
        @(negedge clk);
        acc = v && in_ready && rst_n;
        if (acc) exp_q.push_back(use_exp ? e : ref_out(longint'($signed(x)), m));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 0, acc);
    endtask

    task automatic send(input longint x, input bit m, input longint e);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            cycle(1'b1, W'(x), m, 1'b1, 1'b1, e, acc);
            tries++;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: beat x=%0d not accepted, expected acceptance within 20 cycles", x);
        end
    endtask

    task automatic latency_check(input string name);
        bit acc;
        int lat;
        cycle(1'b1, '0, 1'b0, 1'b1, 1'b1, ONE_L / 2, acc);
        check({name, "_accept"}, longint'(acc), 1);
        lat = 1;
        while (!out_valid && lat < 10) begin
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 0, acc);
            lat++;
        end
        check(name, longint'(lat), 3);
    endtask

    // Monitor: scoreboard compare on handoff, hold checks on stall and bubbles.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_z    <= 0;
            was_stall <= 1'b0;
        end else begin
            if (was_stall) begin
                check("stall_valid", longint'(out_valid), 1);
                check("stall_z", longint'($signed(out_z)), held_z);
            end else if (!out_valid) begin
                check("bubble_z", longint'($signed(out_z)), held_z);
            end
            if (out_valid && !out_ready) check("stall_in_ready", longint'(in_ready), 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_extra: got out_z=%0d, expected no output", $signed(out_z));
                end else begin
                    e_pop = exp_q.pop_front();
                    check("out_z", longint'($signed(out_z)), e_pop);
                end
            end
            if (out_valid) held_z <= longint'($signed(out_z));
            was_stall <= out_valid && !out_ready;
        end
    end

    initial begin
        bit          acc;
        int          n_acc;
        int          cyc;
        logic [W-1:0] xv;
        longint      bp_x[8] = '{0, 65536, -65536, 131072, 196608, -196608, 327680, -524288};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_z", longint'($signed(out_z)), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        rst_n = 1'b1;

        latency_check("latency");
        idle(4);

        // Sigmoid, positive and negative points.
        send(0, 1'b0, 32768);
        send(65536, 1'b0, 49152);
        send(131072, 1'b0, 57344);
        send(196608, 1'b0, 61440);
        send(327680, 1'b0, 65536);
        send(-65536, 1'b0, 16384);
        send(-196608, 1'b0, 4096);
        send(-327680, 1'b0, 0);
        send(-524288, 1'b0, 0);
`ifdef PWL_TANH_EN
        send(0, 1'b1, 0);
        send(32768, 1'b1, 32768);
        send(-32768, 1'b1, -32768);
        send(163840, 1'b1, 65536);
`endif
        idle(6);
        check("directed_drain", longint'(exp_q.size()), 0);

        // Backpressure: 8 beats, out_ready low for 4 cycles mid-stream.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 8 && cyc < 60) begin
            cycle(1'b1, W'(bp_x[n_acc]), 1'b0, !(cyc >= 4 && cyc < 8), 1'b0, 0, acc);
            if (acc) n_acc++;
            cyc++;
        end
        check("bp_accepted", longint'(n_acc), 8);
        idle(6);
        check("bp_drain", longint'(exp_q.size()), 0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(bp_x[i + 3]), 1'b0, 1'b1, 1'b0, 0, acc);
        #2;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_out_z", longint'($signed(out_z)), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        latency_check("latency_after_rst");
        idle(4);

        // Random traffic, mixed modes, random valid and ready.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            case ($urandom_range(0, 3))
                0: xv = W'($urandom);
                1: begin
                    xv = W'(corners[$urandom_range(0, 13)]);
                    if ($urandom_range(0, 1) == 1) xv = -xv;
                end
                default: begin
                    xv = W'($urandom_range(0, 6 << F));
                    if ($urandom_range(0, 1) == 1) xv = -xv;
                end
            endcase
            cycle($urandom_range(0, 9) < 7, xv, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 7, 1'b0, 0, acc);
            if (acc) n_acc++;
            cyc++;
        end
        check("rand_accepted", longint'(n_acc), 10000);
        idle(8);
        check("rand_drain", longint'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
